// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback port arbiter.
// Used by wb_arb_fifo and wb_port_arbiter.
package wb_arb_pkg;

  localparam int DEPTH_DEF      = 4;
  localparam int STARVE_MAX_DEF = 8;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    FORCE
  } wb_arb_state_e;

endpackage

// File: rtl/wb_arb_fifo.sv
// Long-latency result buffer: ring storage, kill-by-address,
// and pending-register mask.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [4:0]    push_addr,
  input  logic [31:0]   push_data,
  input  logic          pop,
  input  logic          kill,
  input  logic [4:0]    kill_addr,
  output wb_entry_t     head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic [31:0]   pend_mask
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i].valid <= 1'b0;
    end else begin
      if (kill)
        for (int i = 0; i < DEPTH; i++)
          if (mem[i].valid && mem[i].rd_addr == kill_addr)
            mem[i].valid <= 1'b0;
      if (pop) begin
        mem[rd_ptr].valid <= 1'b0;
        rd_ptr <= rd_ptr + PW'(1);
      end
      // a push never lands on a slot being killed: new entries survive
      if (push) begin
        mem[wr_ptr] <= wb_entry_t'{
          valid:   1'b1,
          rd_addr: push_addr,
          rd_data: push_data
        };
        wr_ptr <= wr_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i].valid)
        pend_mask[mem[i].rd_addr] = 1'b1;
    if (push)
      pend_mask[push_addr] = 1'b1;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by pipeline and long-latency units.
// Define WB_ARB_STARVE_EN to build the starve counter and FORCE stall state.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pipe_wren,
  input  logic [4:0]  i_pipe_rd_addr,
  input  logic [31:0] i_pipe_rd_data,
  input  logic        i_ll_valid,
  input  logic [4:0]  i_ll_rd_addr,
  input  logic [31:0] i_ll_rd_data,
  output logic        o_ll_ready,
  output logic        o_rd_wren,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic [31:0] o_pend_mask,
  output logic        o_stall
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t     head;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic          empty;
  logic          full;
  logic          xfer;
  logic          deq;
  logic          bypass;
  logic          enq;
  logic          drained;
  wb_arb_state_e state;
  wb_arb_state_e state_n;

  assign o_ll_ready = !full;
  assign xfer       = i_ll_valid && !full;
  assign deq        = !i_pipe_wren && !empty;
  assign bypass     = xfer && empty && !i_pipe_wren;
  assign enq        = xfer && !bypass && (i_ll_rd_addr != '0);
  assign count_n    = count + CW'(enq) - CW'(deq);
  assign drained    = (count_n == '0);

  wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (enq),
    .push_addr (i_ll_rd_addr),
    .push_data (i_ll_rd_data),
    .pop       (deq),
    .kill      (i_pipe_wren),
    .kill_addr (i_pipe_rd_addr),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .pend_mask (o_pend_mask)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rd_wren <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else begin
      unique case (1'b1)
        i_pipe_wren: begin
          o_rd_wren <= (i_pipe_rd_addr != '0);
          o_rd_addr <= i_pipe_rd_addr;
          o_rd_data <= i_pipe_rd_data;
        end
        deq: begin
          o_rd_wren <= head.valid;
          o_rd_addr <= head.rd_addr;
          o_rd_data <= head.rd_data;
        end
        bypass: begin
          o_rd_wren <= (i_ll_rd_addr != '0);
          o_rd_addr <= i_ll_rd_addr;
          o_rd_data <= i_ll_rd_data;
        end
        default: o_rd_wren <= 1'b0;
      endcase
    end
  end

`ifdef WB_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve;
  logic [SW-1:0] starve_n;
  logic          blocked;

  assign blocked = i_pipe_wren && !empty;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      state  <= state_n;
      starve <= starve_n;
    end
  end

  always_comb begin
    state_n  = state;
    starve_n = starve;
    o_stall  = 1'b0;
    unique case (state)
      IDLE: if (enq) state_n = PEND;
      PEND: begin
        if (deq)
          starve_n = '0;
        else if (blocked)
          starve_n = starve + SW'(1);
        if (drained)
          state_n = IDLE;
        else if (starve_n == SW'(STARVE_MAX))
          state_n = FORCE;
      end
      FORCE: begin
        o_stall  = 1'b1;
        starve_n = '0;
        state_n  = drained ? IDLE : PEND;
      end
      default: state_n = IDLE;
    endcase
  end
`else
  assign o_stall = 1'b0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (enq) state_n = PEND;
      PEND:    if (drained) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed table,
// corner sequences, and random traffic against a queue model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 4;
  localparam int SMAX  = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_pipe_wren = 1'b0;
  logic [4:0]  i_pipe_rd_addr = '0;
  logic [31:0] i_pipe_rd_data = '0;
  logic        i_ll_valid = 1'b0;
  logic [4:0]  i_ll_rd_addr = '0;
  logic [31:0] i_ll_rd_data = '0;
  logic        o_ll_ready;
  logic        o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic [31:0] o_pend_mask;
  logic        o_stall;

  always #5 i_clk = ~i_clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_pipe_wren    (i_pipe_wren),
    .i_pipe_rd_addr (i_pipe_rd_addr),
    .i_pipe_rd_data (i_pipe_rd_data),
    .i_ll_valid     (i_ll_valid),
    .i_ll_rd_addr   (i_ll_rd_addr),
    .i_ll_rd_data   (i_ll_rd_data),
    .o_ll_ready     (o_ll_ready),
    .o_rd_wren      (o_rd_wren),
    .o_rd_addr      (o_rd_addr),
    .o_rd_data      (o_rd_data),
    .o_pend_mask    (o_pend_mask),
    .o_stall        (o_stall)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // inputs change on the falling edge; outputs are sampled 1ns later
  task automatic drive(bit pw, bit [4:0] pa, bit [31:0] pd,
                       bit lv, bit [4:0] la, bit [31:0] ld);
    @(negedge i_clk);
    i_pipe_wren    = pw;
    i_pipe_rd_addr = pa;
    i_pipe_rd_data = pd;
    i_ll_valid     = lv;
    i_ll_rd_addr   = la;
    i_ll_rd_data   = ld;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(string tag);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_pipe_wren = 1'b0;
    i_ll_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk({tag, "_rst_wren"}, o_rd_wren, 0);
    chk({tag, "_rst_addr"}, o_rd_addr, 0);
    chk({tag, "_rst_data"}, o_rd_data, 0);
    chk({tag, "_rst_ready"}, o_ll_ready, 1);
    chk({tag, "_rst_mask"}, o_pend_mask, 0);
    chk({tag, "_rst_stall"}, o_stall, 0);
  endtask

  typedef struct {
    bit        pw;
    bit [4:0]  pa;
    bit [31:0] pd;
    bit        lv;
    bit [4:0]  la;
    bit [31:0] ld;
    bit        ew;
    bit [4:0]  ea;
    bit [31:0] ed;
    bit        er;
    bit [31:0] em;
  } vec_t;

  function automatic vec_t mk(bit pw, bit [4:0] pa, bit [31:0] pd,
                              bit lv, bit [4:0] la, bit [31:0] ld,
                              bit ew, bit [4:0] ea, bit [31:0] ed,
                              bit er, bit [31:0] em);
    vec_t v;
    v.pw = pw; v.pa = pa; v.pd = pd;
    v.lv = lv; v.la = la; v.ld = ld;
    v.ew = ew; v.ea = ea; v.ed = ed;
    v.er = er; v.em = em;
    return v;
  endfunction

  typedef struct {
    bit [4:0]  a;
    bit [31:0] d;
    bit        live;
  } mq_t;

  mq_t       q[$];
  bit        m_ew;
  bit [4:0]  m_ea;
  bit [31:0] m_ed;
  int        m_blk;
  bit        m_frc;

  task automatic model_reset();
    q.delete();
    m_ew = 0;
    m_ea = 0;
    m_ed = 0;
    m_blk = 0;
    m_frc = 0;
  endtask

  initial begin
    vec_t tv[$];
    bit bubble;

    do_reset("init");

    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tv.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 7, 32'h1234, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 32'h1234, 1, 0));
    tv.push_back(mk(1, 1, 1, 1, 8, 32'h80, 0, 0, 0, 1, 32'h100));
    tv.push_back(mk(1, 2, 2, 1, 9, 32'h90, 1, 1, 1, 1, 32'h300));
    tv.push_back(mk(1, 3, 3, 1, 10, 32'hA0, 1, 2, 2, 1, 32'h700));
    tv.push_back(mk(1, 4, 4, 1, 11, 32'hB0, 1, 3, 3, 1, 32'hF00));
    tv.push_back(mk(1, 6, 6, 1, 13, 32'hD0, 1, 4, 4, 0, 32'hF00));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6, 6, 0, 32'hF00));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8, 32'h80, 1, 32'hE00));
    tv.push_back(mk(1, 10, 32'hAAAA, 0, 0, 0, 1, 9, 32'h90, 1, 32'hC00));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 10, 32'hAAAA, 1, 32'h800));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h800));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 11, 32'hB0, 1, 0));
    tv.push_back(mk(1, 0, 32'hFFFF, 1, 0, 5, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 1, 0, 6, 0, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tv.push_back(mk(1, 15, 1, 1, 15, 32'hF5, 0, 0, 0, 1, 32'h8000));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 15, 1, 1, 32'h8000));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 15, 32'hF5, 1, 0));

    foreach (tv[i]) begin
      drive(tv[i].pw, tv[i].pa, tv[i].pd, tv[i].lv, tv[i].la, tv[i].ld);
      chk($sformatf("tbl%0d_wren", i), o_rd_wren, tv[i].ew);
      if (tv[i].ew) begin
        chk($sformatf("tbl%0d_addr", i), o_rd_addr, tv[i].ea);
        chk($sformatf("tbl%0d_data", i), o_rd_data, tv[i].ed);
      end
      chk($sformatf("tbl%0d_ready", i), o_ll_ready, tv[i].er);
      chk($sformatf("tbl%0d_mask", i), o_pend_mask, tv[i].em);
      chk($sformatf("tbl%0d_stall", i), o_stall, 0);
    end

    // starvation: one buffered entry behind a continuous pipeline stream
    do_reset("starve");
    drive(1, 1, 1, 1, 20, 32'h2020);
`ifdef WB_ARB_STARVE_EN
    for (int k = 1; k <= SMAX; k++) begin
      drive(1, 2, k, 0, 0, 0);
      chk($sformatf("starve_blk%0d_stall", k), o_stall, 0);
      chk($sformatf("starve_blk%0d_mask", k), o_pend_mask, 32'h0010_0000);
    end
    drive(1, 3, 9, 0, 0, 0);
    chk("starve_force_stall", o_stall, 1);
    idle();
    chk("starve_bubble_stall", o_stall, 0);
    idle();
    chk("starve_drain_wren", o_rd_wren, 1);
    chk("starve_drain_addr", o_rd_addr, 20);
    chk("starve_drain_data", o_rd_data, 32'h2020);
`else
    for (int k = 1; k <= SMAX + 4; k++) begin
      drive(1, 2, k, 0, 0, 0);
      chk($sformatf("nostarve_blk%0d_stall", k), o_stall, 0);
      chk($sformatf("nostarve_blk%0d_mask", k), o_pend_mask, 32'h0010_0000);
    end
    idle();
    idle();
    chk("nostarve_drain_wren", o_rd_wren, 1);
    chk("nostarve_drain_addr", o_rd_addr, 20);
    chk("nostarve_drain_data", o_rd_data, 32'h2020);
`endif

    // reset with three buffered entries discards them
    do_reset("flush_pre");
    drive(1, 1, 1, 1, 21, 32'h21);
    drive(1, 2, 2, 1, 22, 32'h22);
    drive(1, 3, 3, 1, 23, 32'h23);
    chk("flush_pre_mask", o_pend_mask, 32'h00E0_0000);
    do_reset("flush");
    for (int k = 0; k < 4; k++) begin
      idle();
      chk($sformatf("flush_idle%0d_wren", k), o_rd_wren, 0);
      chk($sformatf("flush_idle%0d_mask", k), o_pend_mask, 0);
    end

    // random traffic against the queue model
    do_reset("rand");
    model_reset();
    bubble = 0;
    for (int c = 0; c < 3000; c++) begin
      bit        pw, lv, rdy, byp, acc, stall_now;
      bit [4:0]  pa, la;
      bit [31:0] pd, ld, em;
      int        sz;
      mq_t       m;
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rand_mid");
        model_reset();
        bubble = 0;
        continue;
      end
      pw = bubble ? 1'b0 : ($urandom_range(0, 99) < 65);
      pa = 5'($urandom_range(0, 15));
      pd = $urandom;
      lv = 1'($urandom_range(0, 1));
      la = 5'($urandom_range(0, 15));
      ld = $urandom;
      drive(pw, pa, pd, lv, la, ld);

      sz  = q.size();
      rdy = (sz < DEPTH);
      byp = lv && rdy && sz == 0 && !pw;
      acc = lv && rdy && !byp && la != 0;
      em  = '0;
      foreach (q[i])
        if (q[i].live) em[q[i].a] = 1'b1;
      if (acc) em[la] = 1'b1;
      stall_now = m_frc;

      chk($sformatf("rnd%0d_wren", c), o_rd_wren, m_ew);
      if (m_ew) begin
        chk($sformatf("rnd%0d_addr", c), o_rd_addr, m_ea);
        chk($sformatf("rnd%0d_data", c), o_rd_data, m_ed);
      end
      chk($sformatf("rnd%0d_ready", c), o_ll_ready, rdy);
      chk($sformatf("rnd%0d_mask", c), o_pend_mask, em);
      chk($sformatf("rnd%0d_stall", c), o_stall, stall_now);

`ifdef WB_ARB_STARVE_EN
      if (m_frc) begin
        m_frc = 0;
        m_blk = 0;
      end else if (pw && sz > 0) begin
        m_blk++;
        if (m_blk == SMAX) begin
          m_frc = 1;
          m_blk = 0;
        end
      end else begin
        m_blk = 0;
      end
`endif
      bubble = stall_now;

      if (pw) begin
        m_ew = (pa != 0);
        m_ea = pa;
        m_ed = pd;
        foreach (q[i])
          if (q[i].a == pa) q[i].live = 1'b0;
      end else if (sz > 0) begin
        m = q.pop_front();
        m_ew = m.live;
        m_ea = m.a;
        m_ed = m.d;
      end else if (byp) begin
        m_ew = (la != 0);
        m_ea = la;
        m_ed = ld;
      end else begin
        m_ew = 0;
      end
      if (acc) q.push_back(mq_t'{a: la, d: ld, live: 1'b1});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
